bcd_display_mux: RTL
====================

Name: bcd_display_mux

Overview:
- Time-multiplexed 7-segment driver for the two-digit BCD counter. It consumes the counter's digit_1 and digit_10 outputs and drives two common-anode digits.
- Shadow-latches both digits once per frame, so the display never tears while the counter updates.
- Adds anti-ghosting guard time and optional leading-zero blanking.

Parameters:
- DIV, 1000: clocks per digit slot; frame = 2*DIV clocks; legal range 2..65535.
- GUARD, 2: clocks at start of each slot with all anodes inactive; legal range 1..DIV-1.
- SEG_ACTIVE_LOW, 1: 1 = segment on drives 0; 0 = segment on drives 1.
- AN_ACTIVE_LOW, 1: 1 = anode on drives 0; 0 = anode on drives 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- digit_1  input  4  BCD units digit from the counter.
- digit_10  input  4  BCD tens digit from the counter.
- lz_blank  input  1  1 = blank the tens digit when its latched value is 0.
- seg  output  7  segment drive, seg[0]=a … seg[6]=g.
- an  output  2  anode drive, an[0]=units, an[1]=tens.
- frame_tick  output  1  1-cycle pulse on the last clock of each frame.

Behaviour:
- State registers:
  - cnt: slot counter, 0..DIV-1, width clog2(DIV).
  - slot: 0 = units, 1 = tens.
  - sh1, sh10: 4-bit shadow digits.
  - shlz: latched copy of lz_blank.
- Outputs are a combinational decode of the registered state. There is no extra pipeline stage.
- Reset (synchronous, any cycle, including mid-slot) sets cnt=0, slot=0, sh1=sh10=0, shlz=0. While reset is asserted and on the first cycle after release:
  - an inactive (both anodes off)
  - seg all-off
  - frame_tick=0
- Counter and slot sequencing:
  - cnt increments each clock.
  - When cnt==DIV-1, cnt wraps to 0 and slot toggles.
  - No enable input; the driver runs continuously.
- frame_tick = (slot==1 && cnt==DIV-1). Period is exactly 2*DIV clocks. The first pulse is on the 2*DIV-th clock after reset release.
- Shadow latch:
  - Loads only on the edge where frame_tick==1: sh1<=digit_1, sh10<=digit_10, shlz<=lz_blank.
  - Input changes at any other time have no visible effect until the next frame.
  - Simultaneous reset and frame_tick: reset wins.
- Anode enables:
  - Both off when cnt<GUARD.
  - Otherwise, slot 0 enables an[0].
  - Slot 1 enables an[1], unless shlz==1 && sh10==0, in which case both stay off for the whole slot.
  - At most one anode is active in any cycle.
- Segment decode (on-pattern g..a) for the selected shadow digit:
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
  - 10–15 (invalid BCD) = 1000000, a dash (g only).
- seg is forced all-off whenever no anode is active.
- Polarity: inversion is applied last, per SEG_ACTIVE_LOW / AN_ACTIVE_LOW. With both at 1 (defaults):
  - "off" = seg 7'h7F, an 2'b11.
  - Units active = an 2'b10; tens active = an 2'b01.

Test Plan (DIV=4, GUARD=1, default polarities):
1. Reset held 3 clocks, then released:
   - During reset and the following cycle: an=2'b11, seg=7'h7F, frame_tick=0.
   - Cycles 1–3 of slot 0: an=2'b10, seg=7'h40 (shows 0).
   - frame_tick high on clock 8 only, then every 8 clocks.
2. digit_1=4, digit_10=7 applied before the first frame_tick:
   - Next frame, units slot cnt 1..3: an=2'b10, seg=7'h19.
   - Tens slot cnt 1..3: an=2'b01, seg=7'h78.
   - cnt 0 of each slot: an=2'b11, seg=7'h7F.
3. Inputs changed to 2/3 in mid-frame (cnt=2, slot 0):
   - Current frame still shows 4/7.
   - Following frame shows units seg=7'h24, tens seg=7'h30.
4. digit_10=0, digit_1=5:
   - lz_blank=1 → tens slot an=2'b11, seg=7'h7F for all 4 clocks; units seg=7'h12.
   - lz_blank=0 → tens shows seg=7'h40.
5. digit_1=4'hC → units seg=7'h3F (dash). Tens unaffected.
6. reset pulsed 1 clock at tens slot cnt=2 while showing 4/7:
   - Next cycle: an=2'b11, cnt=0, slot=0.
   - First frame shows 0/0; frame_tick occurs exactly 8 clocks after release.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Two-digit common-anode 7-segment scanner with per-frame shadow latch, guard time and leading-zero blanking.
// Latency: outputs are a combinational decode of the registered scan state; shadow digits update on the clock after frame_tick.
// Backpressure: none; the scan runs free every clock and input changes wait for the next frame boundary.
module bcd_display_mux #(
  parameter int DIV            = 1000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_10,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GRD  = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic          slot;
  logic [3:0]    sh1;
  logic [3:0]    sh10;
  logic          shlz;

  logic          slot_last;
  logic [1:0]    an_on;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_on;

  assign slot_last  = (cnt == CNT_LAST);
  assign frame_tick = slot & slot_last;

  // Scan counter, slot toggle and frame-boundary shadow latch; reset overrides a coincident frame_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      slot <= 1'b0;
      sh1  <= 4'd0;
      sh10 <= 4'd0;
      shlz <= 1'b0;
    end else begin
      if (slot_last) begin
        cnt  <= '0;
        slot <= ~slot;
      end else begin
        cnt  <= cnt + CW'(1);
      end
      if (frame_tick) begin
        sh1  <= digit_1;
        sh10 <= digit_10;
        shlz <= lz_blank;
      end
    end
  end

  // Anode select: dark during the guard window, and tens stays dark for a blanked leading zero.
  always_comb begin
    an_on = 2'b00;
    if (cnt >= CNT_GRD) begin
      if (!slot) begin
        an_on = 2'b01;
      end else if (!(shlz && (sh10 == 4'd0))) begin
        an_on = 2'b10;
      end
    end
  end

  assign cur_digit = slot ? sh10 : sh1;

  // Segment decode (active-high, g..a) of the slot's shadow digit; dash for non-BCD, dark when no anode is on.
  always_comb begin
    seg_on = 7'b0000000;
    case (cur_digit)
      4'd0:    seg_on = 7'b0111111;
      4'd1:    seg_on = 7'b0000110;
      4'd2:    seg_on = 7'b1011011;
      4'd3:    seg_on = 7'b1001111;
      4'd4:    seg_on = 7'b1100110;
      4'd5:    seg_on = 7'b1101101;
      4'd6:    seg_on = 7'b1111101;
      4'd7:    seg_on = 7'b0000111;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1101111;
      default: seg_on = 7'b1000000;
    endcase
    if (an_on == 2'b00) begin
      seg_on = 7'b0000000;
    end
  end

  // Board polarity is applied as the very last step.
  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
  assign an  = (AN_ACTIVE_LOW  != 0) ? ~an_on  : an_on;

endmodule
